// File: rtl/jedro_1_alu_issue.sv
// Decode and issue stage for the jedro_1 ALU path (OP, OP-IMM, LUI).
// It holds one instruction, stalls one cycle on a RAW hazard and bypasses the registered ALU result.
module jedro_1_alu_issue (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic [3:0]  alu_sel_o,
    output logic [31:0] alu_op_a_o,
    output logic [31:0] alu_op_b_o,
    output logic [4:0]  alu_dest_addr_o,
    output logic        alu_wb_o,
    input  logic [31:0] alu_res_i,
    input  logic [4:0]  alu_dest_addr_i,
    input  logic        alu_wb_i,
    output logic        illegal_o
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        DECODE = 2'd1,
        STALL  = 2'd2
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    state_e      state_r;
    logic [31:0] ir_r;

    logic [6:0]  opcode_s;
    logic [6:0]  funct7_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic        legal_s;
    logic        use_rs1_s;
    logic        use_rs2_s;
    logic        hazard_s;
    logic        accept_s;
    logic [3:0]  sel_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] op_a_s;
    logic [31:0] op_b_s;

    assign opcode_s   = ir_r[6:0];
    assign rd_s       = ir_r[11:7];
    assign funct3_s   = ir_r[14:12];
    assign rs1_s      = ir_r[19:15];
    assign rs2_s      = ir_r[24:20];
    assign funct7_s   = ir_r[31:25];
    assign rs1_addr_o = rs1_s;
    assign rs2_addr_o = rs2_s;
    assign accept_s   = instr_valid_i && instr_ready_o;

    // Source operand values: x0 is hard zero, otherwise bypass the ALU result when it targets rs
    always_comb begin
        rs1_val_s = 32'd0;
        rs2_val_s = 32'd0;
        if (rs1_s == 5'd0) begin
            rs1_val_s = 32'd0;
        end else if (alu_wb_i && (alu_dest_addr_i == rs1_s)) begin
            rs1_val_s = alu_res_i;
        end else begin
            rs1_val_s = rs1_data_i;
        end
        if (rs2_s == 5'd0) begin
            rs2_val_s = 32'd0;
        end else if (alu_wb_i && (alu_dest_addr_i == rs2_s)) begin
            rs2_val_s = alu_res_i;
        end else begin
            rs2_val_s = rs2_data_i;
        end
    end

    // Decode of the held instruction into ALU select, operands and used sources
    always_comb begin
        legal_s   = 1'b0;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        sel_s     = 4'd0;
        op_a_s    = 32'd0;
        op_b_s    = 32'd0;
        case (opcode_s)
            OPC_OP: begin
                legal_s   = (funct7_s == 7'b0000000) ||
                            ((funct7_s == 7'b0100000) &&
                             ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                sel_s     = {ir_r[30], funct3_s};
                op_a_s    = rs1_val_s;
                op_b_s    = rs2_val_s;
            end
            OPC_OP_IMM: begin
                legal_s   = 1'b1;
                use_rs1_s = 1'b1;
                sel_s     = {((funct3_s == 3'b101) ? ir_r[30] : 1'b0), funct3_s};
                op_a_s    = rs1_val_s;
                // shifts take the 5-bit shamt, everything else the sign-extended immediate
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    op_b_s = {27'd0, ir_r[24:20]};
                end else begin
                    op_b_s = {{20{ir_r[31]}}, ir_r[31:20]};
                end
            end
            OPC_LUI: begin
                legal_s = 1'b1;
                op_b_s  = {ir_r[31:12], 12'd0};
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // RAW hazard against the op currently in the ALU, and the accept handshake
    always_comb begin
        hazard_s      = 1'b0;
        instr_ready_o = 1'b0;
        if ((state_r == DECODE) && legal_s && alu_wb_o && (alu_dest_addr_o != 5'd0)) begin
            hazard_s = (use_rs1_s && (alu_dest_addr_o == rs1_s)) ||
                       (use_rs2_s && (alu_dest_addr_o == rs2_s));
        end else begin
            hazard_s = 1'b0;
        end
        if (rst_i) begin
            instr_ready_o = 1'b0;
        end else if (state_r == EMPTY) begin
            instr_ready_o = 1'b1;
        end else if (state_r == DECODE) begin
            instr_ready_o = !hazard_s;
        end else begin
            instr_ready_o = 1'b0;
        end
    end

    // FSM, instruction register and registered issue outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r         <= EMPTY;
            ir_r            <= 32'd0;
            alu_sel_o       <= 4'd0;
            alu_op_a_o      <= 32'd0;
            alu_op_b_o      <= 32'd0;
            alu_dest_addr_o <= 5'd0;
            alu_wb_o        <= 1'b0;
            illegal_o       <= 1'b0;
        end else begin
            alu_sel_o       <= 4'd0;
            alu_op_a_o      <= 32'd0;
            alu_op_b_o      <= 32'd0;
            alu_dest_addr_o <= 5'd0;
            alu_wb_o        <= 1'b0;
            illegal_o       <= 1'b0;
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        ir_r    <= instr_i;
                        state_r <= DECODE;
                    end else begin
                        ir_r    <= 32'd0;
                        state_r <= EMPTY;
                    end
                end
                DECODE, STALL: begin
                    if (hazard_s) begin
                        state_r <= STALL;
                    end else begin
                        if (legal_s) begin
                            alu_sel_o       <= sel_s;
                            alu_op_a_o      <= op_a_s;
                            alu_op_b_o      <= op_b_s;
                            alu_dest_addr_o <= rd_s;
                            alu_wb_o        <= 1'b1;
                        end else begin
                            illegal_o <= 1'b1;
                        end
                        if (accept_s) begin
                            ir_r    <= instr_i;
                            state_r <= DECODE;
                        end else begin
                            ir_r    <= 32'd0;
                            state_r <= EMPTY;
                        end
                    end
                end
                default: begin
                    ir_r    <= 32'd0;
                    state_r <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/jedro_1_alu_issue.md
JEDRO_1_ALU_ISSUE -- requirements
Module: jedro_1_alu_issue

Interface
REQ-001 Parameters: none. Widths SHALL come from jedro_1_defines: DATA_WIDTH=32, ALU_OP_WIDTH=4, REG_ADDR_WIDTH=5.
REQ-002 Clocking and reset SHALL be one clock with synchronous, active-high reset.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 instr_i  in  32  RV32I instruction word.
REQ-006 instr_valid_i  in  1  instr_i valid.
REQ-007 instr_ready_o  out  1  block accepts instr_i this cycle.
REQ-008 rs1_addr_o, rs2_addr_o  out  5 each  register-file read addresses; combinational read data returns the same cycle.
REQ-009 rs1_data_i, rs2_data_i  in  32 each  register-file read data.
REQ-010 alu_sel_o  out  4  ALU operation, encoded {sub/arith bit, funct3}.
REQ-011 alu_op_a_o, alu_op_b_o  out  32 each  ALU operands.
REQ-012 alu_dest_addr_o  out  5  destination register.
REQ-013 alu_wb_o  out  1  issued op writes back; 0 marks a bubble.
REQ-014 alu_res_i  in  32  registered ALU result, used for forwarding.
REQ-015 alu_dest_addr_i  in  5  registered ALU destination.
REQ-016 alu_wb_i  in  1  registered ALU writeback flag.
REQ-017 illegal_o  out  1  one-cycle pulse for an unsupported instruction.

Function
REQ-018 Accept rule: an instruction SHALL be accepted when instr_valid_i && instr_ready_o; accepted words are latched into an internal instruction register (IR).
REQ-019 FSM states SHALL be EMPTY, DECODE and STALL.
- EMPTY -> DECODE on accept.
- DECODE -> STALL on hazard.
- DECODE -> DECODE on issue with a new accept.
- DECODE -> EMPTY on issue without accept.
- STALL -> DECODE/EMPTY by the same accept rule.
REQ-020 instr_ready_o SHALL be 1 in EMPTY, 1 in DECODE when no hazard, 0 in STALL, 0 during reset.
REQ-021 Latency: accept at edge E0 SHALL give alu_* outputs registered at E1 (no hazard) or E2 (hazard); ALU result follows one cycle later.
REQ-022 OP (0110011) decode: alu_sel_o = {instr[30], funct3}; rs2 supplies op_b.
REQ-023 OP-IMM (0010011) decode: alu_sel_o = {instr[30] when funct3=101 else 0, funct3}; op_b = sign-extended imm[11:0]; for SLLI/SRLI/SRAI op_b = zero-extended instr[24:20].
REQ-024 LUI (0110111) decode: alu_sel_o = ADD (0000), op_a = 0, op_b = {instr[31:12], 12'b0}.
REQ-025 rd = instr[11:7]; alu_wb_o SHALL be 1 for every legal op, including when rd = x0.
REQ-026 Illegal instruction: any other opcode, or OP with funct7 outside {0000000, 0100000(f3=000/101)}, SHALL pulse illegal_o for one cycle, issue a bubble and drop the IR.
REQ-027 Hazard: in DECODE, hazard = alu_wb_o && alu_dest_addr_o != 0 && alu_dest_addr_o matches a used rs; used rs excludes rs2 for OP-IMM and both rs for LUI.
REQ-028 On hazard the block SHALL issue a bubble (alu_wb_o=0, alu_sel_o=0, operands 0, dest 0) and hold the IR.
REQ-029 Forwarding: an operand SHALL be taken from alu_res_i when alu_wb_i && alu_dest_addr_i == rs && rs != 0, otherwise from rs*_data_i; this applies in DECODE and STALL.
REQ-030 Register x0 SHALL read 0 regardless of rs*_data_i.
REQ-031 When the IR is empty the block SHALL issue bubbles every cycle.

Reset
REQ-032 While rst_i=1 at a clock edge, the block SHALL clear FSM to EMPTY and clear the IR.
REQ-033 While rst_i=1 at a clock edge, all registered outputs SHALL be 0 (alu_sel_o, alu_op_a_o, alu_op_b_o, alu_dest_addr_o, alu_wb_o, illegal_o).
REQ-034 Reset asserted mid-stall or mid-decode SHALL discard the held instruction with no issue.
REQ-035 instr_ready_o SHALL rise the cycle after rst_i deasserts.

Verification
REQ-036 0x00500093 (addi x1,x0,5) -> next edge: sel=0000, a=0, b=5, dest=1, wb=1.
REQ-037 0x00108133 (add x2,x1,x1) back-to-back after REQ-036 -> one bubble (wb=0, ready=0), then a=b=5 forwarded from alu_res_i=5, dest=2.
REQ-038 0x401101B3 (sub x3,x2,x1), no hazard, regfile x2=10, x1=5 -> sel=1000, a=10, b=5, dest=3.
REQ-039 0x4021D213 (srai x4,x3,2) -> sel=1101, b=2; 0x123452B7 (lui x5) -> sel=0000, a=0, b=0x12345000, dest=5.
REQ-040 0x00000000 -> illegal_o pulses one cycle, wb=0, ready returns 1.
REQ-041 rst_i=1 during STALL -> all outputs 0; no issue after release.
